// File: rtl/encoder_2nrm_seq.sv
// encoder_2nrm_seq
//   Sequential 2NRM-RRNS encoder. Takes one 16-bit word and computes its
//   residues over {257, 256, 61, 59, 55, 53} serially, one data bit per
//   cycle, MSB first, using shift-and-conditional-subtract reduction.
//   Accept-to-valid latency is 16 edges. With out_ready held high, one word
//   completes every 18 cycles.
//
// Optional feature macro: ENC_2NRM_CNT_EN (adds the enc_count port).
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   in_valid   in   in_data valid
//   in_ready   out  encoder idle, can take a word (state decode)
//   in_data    in   [15:0] data word
//   out_valid  out  out_cw holds a finished codeword
//   out_ready  in   consumer takes out_cw
//   out_cw     out  [40:0] {r257[8:0], r256[7:0], r61, r59, r55, r53 [5:0]}
//   enc_count  out  [31:0] codewords delivered (ENC_2NRM_CNT_EN only)
module encoder_2nrm_seq #(
  parameter int DATA_W = 16,
  parameter int CW_W   = 41
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw
`ifdef ENC_2NRM_CNT_EN
  ,
  output logic [31:0]       enc_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [DATA_W-1:0] r_d;
  logic [3:0]  r_cnt;
  logic [8:0]  r_m257;
  logic [7:0]  r_m256;
  logic [5:0]  r_m61, r_m59, r_m55, r_m53;
  logic        w_bit;
  logic        w_accept;
  logic        w_deliver;

  // One reduction step: t = 2r + b is below 2m because r < m, so a single
  // conditional subtract restores r < m.
  function automatic logic [8:0] f_red9(input logic [8:0] r, input logic b,
                                        input logic [9:0] m);
    logic [9:0] t;
    t = {r, b};
    return (t >= m) ? 9'(t - m) : t[8:0];
  endfunction

  function automatic logic [5:0] f_red6(input logic [5:0] r, input logic b,
                                        input logic [6:0] m);
    logic [6:0] t;
    t = {r, b};
    return (t >= m) ? 6'(t - m) : t[5:0];
  endfunction

  assign w_bit     = r_d[DATA_W-1];
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_deliver = (r_state == S_DONE) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)      w_next = S_CALC;
      S_CALC:  if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  if (out_ready)     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register, so neither handshake
  // output depends combinationally on an input.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shift register and residue accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d    <= '0;
      r_cnt  <= '0;
      r_m257 <= '0;
      r_m256 <= '0;
      r_m61  <= '0;
      r_m59  <= '0;
      r_m55  <= '0;
      r_m53  <= '0;
    end else if (w_accept) begin
      r_d    <= in_data;
      r_cnt  <= 4'(DATA_W - 1);
      r_m257 <= '0;
      r_m256 <= '0;
      r_m61  <= '0;
      r_m59  <= '0;
      r_m55  <= '0;
      r_m53  <= '0;
    end else if (r_state == S_CALC) begin
      r_d    <= r_d << 1;
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      r_m257 <= f_red9(r_m257, w_bit, 10'd257);
      // mod 256 keeps the last 8 bits shifted in, i.e. in_data[7:0]
      r_m256 <= {r_m256[6:0], w_bit};
      r_m61  <= f_red6(r_m61, w_bit, 7'd61);
      r_m59  <= f_red6(r_m59, w_bit, 7'd59);
      r_m55  <= f_red6(r_m55, w_bit, 7'd55);
      r_m53  <= f_red6(r_m53, w_bit, 7'd53);
    end
  end

  assign out_cw = {r_m257, r_m256, r_m61, r_m59, r_m55, r_m53};

`ifdef ENC_2NRM_CNT_EN
  logic [31:0] r_enc_count;
  always_ff @(posedge clk) begin
    if (rst)            r_enc_count <= '0;
    else if (w_deliver) r_enc_count <= r_enc_count + 32'd1;
  end
  assign enc_count = r_enc_count;
`else
  logic w_unused;
  assign w_unused = w_deliver;
`endif

endmodule

// File: tb/tb_encoder_2nrm_seq.sv
module tb_encoder_2nrm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [40:0] out_cw;
`ifdef ENC_2NRM_CNT_EN
  logic [31:0] enc_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam int N_B2B = 2000;

  encoder_2nrm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cw    (out_cw)
`ifdef ENC_2NRM_CNT_EN
    ,
    .enc_count (enc_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: residues straight from integer modulo.
  function automatic logic [40:0] model(input logic [15:0] d);
    int v;
    logic [8:0] a;
    logic [7:0] b;
    logic [5:0] c, e, f, g;
    v = int'(d);
    a = 9'(v % 257);
    b = 8'(v % 256);
    c = 6'(v % 61);
    e = 6'(v % 59);
    f = 6'(v % 55);
    g = 6'(v % 53);
    return {a, b, c, e, f, g};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word, returns edges from accept until out_valid (bounded).
  task automatic send(input logic [15:0] d, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_cw !== 41'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_cw=%h, want 1 0 0",
               in_ready, out_valid, out_cw);
    end
`ifdef ENC_2NRM_CNT_EN
    checks++;
    if (enc_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", enc_count);
    end
`endif
  endtask

  task automatic test_vectors();
    logic [15:0] vec [4];
    int lat;
    vec[0] = 16'h0000; vec[1] = 16'hFFFF; vec[2] = 16'h1234; vec[3] = 16'h0101;
    for (int i = 0; i < 4; i++) begin
      send(vec[i], lat);
      checks++;
      if (lat !== 16) begin
        errors++;
        $display("FAIL latency %h: got %0d edges want 16", vec[i], lat);
      end
      checks++;
      if (out_valid !== 1'b1 || out_cw !== model(vec[i])) begin
        errors++;
        $display("FAIL codeword %h: got %h (valid %b) want %h",
                 vec[i], out_cw, out_valid, model(vec[i]));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL handshake %h: out_valid=%b in_ready=%b want 0 1",
                 vec[i], out_valid, in_ready);
      end
    end
    // Spot-check the literal residues for 0xFFFF and 0x1234.
    send(16'hFFFF, lat);
    checks++;
    if (out_cw !== {9'd0, 8'd255, 6'd21, 6'd45, 6'd30, 6'd27}) begin
      errors++;
      $display("FAIL lit_ffff: got %h", out_cw);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send(16'h1234, lat);
    checks++;
    if (out_cw !== {9'd34, 8'd52, 6'd24, 6'd58, 6'd40, 6'd49}) begin
      errors++;
      $display("FAIL lit_1234: got %h", out_cw);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic [40:0] exp;
    int lat, bad;
`ifdef ENC_2NRM_CNT_EN
    logic [31:0] c0;
`endif
    d = 16'($urandom);
    exp = model(d);
    send(d, lat);
`ifdef ENC_2NRM_CNT_EN
    c0 = enc_count;
`endif
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      step();
      if (out_cw !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold: %0d unstable cycles, cw=%h want %h", bad, out_cw, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_handshake: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
`ifdef ENC_2NRM_CNT_EN
    checks++;
    if (enc_count !== c0 + 32'd1) begin
      errors++;
      $display("FAIL hold_count: got %0d want %0d", enc_count, c0 + 32'd1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_cw !== 41'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b cw=%h want 1 0 0",
               in_ready, out_valid, out_cw);
    end
`ifdef ENC_2NRM_CNT_EN
    checks++;
    if (enc_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d want 0", enc_count);
    end
`endif
    send(16'h1234, lat);
    checks++;
    if (lat !== 16 || out_cw !== model(16'h1234)) begin
      errors++;
      $display("FAIL after_reset: lat=%0d cw=%h want 16 %h",
               lat, out_cw, model(16'h1234));
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [40:0] q[$];
    logic [40:0] exp;
    int cyc, last, n_acc, n_done;
    logic acc, done;
`ifdef ENC_2NRM_CNT_EN
    logic [31:0] c0;
    c0 = enc_count;
`endif
    cyc = 0; last = -1; n_acc = 0; n_done = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'($urandom);
    while (n_done < N_B2B && cyc < N_B2B * 18 + 200) begin
      acc  = in_valid && in_ready;
      done = out_valid && out_ready;
      if (done) begin
        exp = (q.size() > 0) ? q.pop_front() : 41'h0;
        checks++;
        if (out_cw !== exp) begin
          errors++;
          $display("FAIL b2b_cw #%0d: got %h want %h", n_done, out_cw, exp);
        end
        n_done++;
      end
      if (acc) begin
        q.push_back(model(in_data));
        if (last >= 0) begin
          checks++;
          if (cyc - last != 18) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 18", cyc - last);
          end
        end
        last = cyc;
        n_acc++;
      end
      step();
      cyc++;
      if (acc) begin
        if (n_acc < N_B2B) in_data = 16'($urandom);
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_done != N_B2B) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d words want %0d", n_done, N_B2B);
    end
`ifdef ENC_2NRM_CNT_EN
    step();
    checks++;
    if (enc_count !== c0 + 32'(N_B2B)) begin
      errors++;
      $display("FAIL b2b_count: got %0d want %0d", enc_count, c0 + 32'(N_B2B));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
